// File: rtl/player_pkg.sv
// Shared opcodes, direction codes and scheduler state encoding
// for the player command path.
package player_pkg;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_HEAL    = 4'h1;
  localparam logic [3:0] OP_DMG     = 4'h2;
  localparam logic [3:0] OP_ATK_ADD = 4'h3;
  localparam logic [3:0] OP_ATK_SET = 4'h4;
  localparam logic [3:0] OP_MOVE    = 4'h5;
  localparam logic [3:0] OP_SET_HP  = 4'h6;

  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_IFRAME = 2'd1,
    ST_DEAD   = 2'd2
  } state_e;

  function automatic logic [15:0] mk_instr(
    input logic [3:0] op,
    input logic [7:0] arg
  );
    return {op, arg, 4'h0};
  endfunction

endpackage

// File: rtl/sched_down_counter.sv
// Loadable down counter that stops at zero; used for the iframe
// window and the move rate limit.
module sched_down_counter #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/player_cmd_sched.sv
// Fixed-priority scheduler for the player instruction port.
// Define PLAYER_SCHED_HITCNT_EN to add the hit_count output.
module player_cmd_sched
  import player_pkg::*;
#(
  parameter int IFRAME_CYCLES = 50_000_000,
  parameter int MOVE_DIV      = 1_000_000,
  parameter int CNT_W         = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sys_valid,
  input  logic [15:0] sys_instr,
  output logic        sys_ready,
  input  logic        dmg_valid,
  input  logic [7:0]  dmg_amt,
  output logic        dmg_ready,
  input  logic        heal_valid,
  input  logic [7:0]  heal_amt,
  output logic        heal_ready,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  output logic        move_ready,
  input  logic        player_dead,
  output logic [15:0] instr,
  output logic        invuln
`ifdef PLAYER_SCHED_HITCNT_EN
  ,
  output logic [7:0]  hit_count
`endif
);

  localparam logic [CNT_W-1:0] IF_LOAD =
    (IFRAME_CYCLES > 0) ? CNT_W'(IFRAME_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] MV_LOAD = CNT_W'(MOVE_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        if_zero, mv_zero, if_load;
  logic        alive, iframe, elig, dmg_hi;
  logic        g_sys, g_dmg, g_heal, g_mv;

  assign alive  = (state_q == ST_ALIVE);
  assign iframe = (state_q == ST_IFRAME);
  assign elig   = rst_n && !player_dead
                  && (state_q != ST_DEAD);
  // dmg only contends for the issue slot when not absorbed
  assign dmg_hi = dmg_valid && alive;

  always_comb begin
    sys_ready  = rst_n && sys_valid;
    dmg_ready  = elig && dmg_valid
                 && (iframe || !sys_valid);
    heal_ready = elig && heal_valid
                 && !sys_valid && !dmg_hi;
    move_ready = elig && move_valid && mv_zero
                 && !sys_valid && !dmg_hi
                 && !heal_valid;
  end

  assign g_sys  = sys_ready;
  assign g_dmg  = dmg_ready && alive;
  assign g_heal = heal_ready;
  assign g_mv   = move_ready;

  always_comb begin
    instr_d = 16'h0000;
    unique case (1'b1)
      g_sys:   instr_d = sys_instr;
      g_dmg:   instr_d = mk_instr(OP_DMG, dmg_amt);
      g_heal:  instr_d = mk_instr(OP_HEAL, heal_amt);
      g_mv:    instr_d = mk_instr(OP_MOVE,
                                  {6'b0, move_dir});
      default: instr_d = 16'h0000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if_load = 1'b0;
    if (player_dead) begin
      state_d = ST_DEAD;
    end else begin
      unique case (state_q)
        ST_ALIVE: begin
          if (g_dmg && (IFRAME_CYCLES > 0)) begin
            state_d = ST_IFRAME;
            if_load = 1'b1;
          end
        end
        ST_IFRAME: begin
          if (if_zero) state_d = ST_ALIVE;
        end
        ST_DEAD:  state_d = ST_ALIVE;
        default:  state_d = ST_ALIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ALIVE;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  sched_down_counter #(.W(CNT_W)) u_iframe_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (player_dead),
    .load     (if_load),
    .load_val (IF_LOAD),
    .en       (iframe),
    .zero     (if_zero)
  );

  sched_down_counter #(.W(CNT_W)) u_move_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (1'b0),
    .load     (g_mv),
    .load_val (MV_LOAD),
    .en       (1'b1),
    .zero     (mv_zero)
  );

  assign instr  = instr_q;
  assign invuln = iframe;

`ifdef PLAYER_SCHED_HITCNT_EN
  logic [7:0] hit_q, hit_d;

  always_comb begin
    hit_d = hit_q;
    if (g_sys && (sys_instr[15:12] == OP_SET_HP)) begin
      hit_d = 8'h00;
    end else if (g_dmg && (hit_q != 8'hFF)) begin
      hit_d = hit_q + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_q <= 8'h00;
    else        hit_q <= hit_d;
  end

  assign hit_count = hit_q;
`endif

endmodule

// File: doc/player_cmd_sched.md
Name: player_cmd_sched

Overview:
- Schedules the 16-bit instruction port of the player stat/position block among four requesters:
  - sys: game-flow FSM, set HP/ATK.
  - dmg: collision detector.
  - heal: item pickup.
  - move: keyboard decoder.
- Issues at most one registered instruction per cycle.
- Enforces a post-hit invulnerability window, a movement rate limit and a dead-player lockout.
- Sits between the gameplay logic and the player block.

Parameters:
- IFRAME_CYCLES, 50_000_000: cycles of invulnerability after an accepted damage; 0 disables the window.
- MOVE_DIV, 1_000_000: minimum cycles between two issued move instructions; minimum value 1.
- CNT_W, 26: width of the iframe and move counters; must hold both parameters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sys_valid  in  1  sys request
- sys_instr  in  16  full instruction; opcode [15:12] must be 3, 4 or 6
- sys_ready  out  1  sys accepted this cycle
- dmg_valid  in  1  damage request
- dmg_amt  in  8  damage amount
- dmg_ready  out  1  damage accepted (issued or absorbed)
- heal_valid  in  1  heal request
- heal_amt  in  8  heal amount
- heal_ready  out  1  heal accepted
- move_valid  in  1  move request
- move_dir  in  2  0 left, 1 up, 2 right, 3 down
- move_ready  out  1  move accepted
- player_dead  in  1  death flag from player block
- instr  out  16  instruction to player block
- invuln  out  1  high during the iframe window (sprite blink)

Behaviour:
- Instruction format: opcode [15:12], operand [11:4], [3:0] zero.
  - Opcodes: 0 NOP, 1 heal, 2 damage, 3 ATK add, 4 ATK set, 5 move, 6 HP set.
- Reset: instr=16'h0000, invuln=0, all ready outputs=0, state=ALIVE, counters=0.
- Ready outputs are combinational from current valids and state.
  - A transfer occurs when valid && ready in the same cycle.
  - instr is registered and reflects the winning request on the next clk edge.
  - With no transfer, instr returns to 16'h0000 in the same way, so every non-NOP instruction is exactly one cycle wide.
- Fixed priority, sys > dmg > heal > move. At most one ready is high per cycle, except in the iframe-absorb case below.
- States:
  - ALIVE: all four sources are eligible.
    - A dmg transfer emits {4'h2, dmg_amt, 4'h0}.
    - If IFRAME_CYCLES>0, the dmg transfer loads the iframe counter with IFRAME_CYCLES-1 and goes to IFRAME.
  - IFRAME: invuln=1.
    - A dmg_valid is absorbed: dmg_ready=1 and no instruction is issued for it. This is concurrent with any other grant.
    - The counter decrements each cycle. At 0 the FSM returns to ALIVE, with invuln low from the next cycle.
  - DEAD: entered from any state when player_dead=1, sampled at the clock edge.
    - Only sys is eligible.
    - dmg, heal and move ready stay 0, so requests are held, not dropped.
    - The iframe counter clears.
    - Returns to ALIVE when player_dead=0.
- Move rate limit: the move counter loads MOVE_DIV-1 on a move transfer and decrements to 0.
  - move_ready requires counter==0 and no higher-priority valid.
  - Emitted instruction: {4'h5, 6'b0, move_dir, 4'h0}.
- Heal emits {4'h1, heal_amt, 4'h0}. sys_instr is passed through unchanged.
- Simultaneous player_dead rise and a dmg grant: DEAD takes precedence, so there is no grant and no iframe load.
- Reset asserted mid-window: counters and state clear immediately, because the reset is asynchronous.

Optional Feature:
- PLAYER_SCHED_HITCNT_EN
- Defined:
  - Adds output hit_count[7:0], reset 0.
  - Increments on every dmg transfer that issues an instruction; absorbed hits are not counted.
  - Saturates at 255.
  - Clears on a sys transfer with opcode 6.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package player_pkg holds:
  - opcode localparams OP_NOP … OP_SET_HP;
  - direction codes DIR_LEFT … DIR_DOWN;
  - the state encoding ST_ALIVE/ST_IFRAME/ST_DEAD.
- One natural sub-module, sched_down_counter: loadable, decrementing, with a zero flag.
  - It is instantiated twice, for the iframe and move counters.

Test Plan:
- Reset release, then move_valid=1 dir=2 with MOVE_DIV=4 -> instr=16'h5020 one cycle after each transfer, transfers spaced exactly 4 cycles, 16'h0000 between them.
- dmg_valid with amt=8'h0A and heal_valid at the same time -> dmg_ready=1, heal_ready=0; next cycle instr=16'h20A0; heal issued one cycle later as 16'h1xx0.
- IFRAME_CYCLES=10: two damage requests 3 cycles apart -> only the first is issued; the second gets dmg_ready=1 with instr=0; invuln high for exactly 10 cycles.
- player_dead=1 with move, heal and dmg valid -> those readies stay 0; sys_instr=16'h6640 is issued; player_dead=0 -> the held dmg is issued the next cycle.
- All four valid simultaneously in ALIVE -> grant order sys, dmg, heal, move over four consecutive transfers.
- rst_n pulsed low mid-iframe -> invuln=0 and instr=0 immediately, without waiting for a clk edge.
